// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Optional feature macro: SWITCH_DEBOUNCER_TOGGLE_EN (adds sw_toggle output).
package switch_debouncer_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 1000;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    // Counter must hold values up to STABLE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: synchronizer chain, qualification counter, stable level and edge pulses.
// Optional feature macro: SWITCH_DEBOUNCER_TOGGLE_EN (adds sw_toggle flop).
module switch_debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    output logic sw_toggle
`endif
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sync;
    logic w_diff;
    logic w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_sync ^ r_stable;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_stable <= w_sync;
            end
            r_rise <= w_accept &  w_sync;
            r_fall <= w_accept & ~w_sync;
        end
    end

    assign sw_stable = r_stable;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_toggle <= 1'b0;
        end else if (w_accept && w_sync) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign sw_toggle = r_toggle;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer: WIDTH independent per-bit conditioning slices.
// Optional feature macro: SWITCH_DEBOUNCER_TOGGLE_EN (adds sw_toggle output).
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] sw_toggle
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
        switch_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .sw_raw   (sw_raw[i]),
            .sw_stable(sw_stable[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .sw_toggle(sw_toggle[i])
        );
`else
        switch_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .sw_raw   (sw_raw[i]),
            .sw_stable(sw_stable[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i])
        );
`endif
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4, STABLE_CYCLES=8, SYNC_STAGES=2.
// Honours SWITCH_DEBOUNCER_TOGGLE_EN when defined.
module tb_switch_debouncer;

    localparam int WIDTH = 4;
    localparam int SC    = 8;
    localparam int SS    = 2;
    localparam int LAT   = SS - 1 + SC;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    logic [WIDTH-1:0] sw_toggle;
`endif

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(SC),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_stable(sw_stable),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
        ,
        .sw_toggle(sw_toggle)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] raw;
        logic             rst_n;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
    } vec_t;

    vec_t             vq[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_tog = '0;

    function automatic void add(input logic [WIDTH-1:0] raw, input logic rst_n,
                                input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r,
                                input logic [WIDTH-1:0] f, input int n);
        vec_t v;
        v.raw = raw; v.rst_n = rst_n; v.s = s; v.r = r; v.f = f;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] es,
                         input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] ef);
        n_vec++;
        if (sw_stable !== es) begin
            n_err++;
            $display("FAIL %s vec %0d: sw_stable got %h want %h", name, n_vec, sw_stable, es);
        end
        if (sw_rise !== er) begin
            n_err++;
            $display("FAIL %s vec %0d: sw_rise got %h want %h", name, n_vec, sw_rise, er);
        end
        if (sw_fall !== ef) begin
            n_err++;
            $display("FAIL %s vec %0d: sw_fall got %h want %h", name, n_vec, sw_fall, ef);
        end
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
        if (!reset) exp_tog = '0;
        else        exp_tog = exp_tog ^ er;
        if (sw_toggle !== exp_tog) begin
            n_err++;
            $display("FAIL %s vec %0d: sw_toggle got %h want %h", name, n_vec, sw_toggle, exp_tog);
        end
`endif
    endtask

    // Drive between edges so the next rising edge samples the new values; look 1 time unit after it.
    task automatic step(input logic [WIDTH-1:0] raw, input logic rst_n);
        @(negedge clk);
        sw_raw = raw;
        reset  = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input logic [WIDTH-1:0] raw, input logic rst_n,
                       input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r,
                       input logic [WIDTH-1:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            step(raw, rst_n);
            check(name, s, r, f);
        end
    endtask

    initial begin
        // Reset held with pins high, then release: all bits qualify together.
        add(4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 3);
        add(4'hF, 1'b1, 4'h0, 4'h0, 4'h0, LAT);
        add(4'hF, 1'b1, 4'hF, 4'hF, 4'h0, 1);
        add(4'hF, 1'b1, 4'hF, 4'h0, 4'h0, 2);
        // Clean press on bit 0 from a fresh reset.
        add(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 2);
        add(4'h1, 1'b1, 4'h0, 4'h0, 4'h0, LAT);
        add(4'h1, 1'b1, 4'h1, 4'h1, 4'h0, 1);
        add(4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 2);
        // Bring bit 2 high, then release it.
        add(4'h5, 1'b1, 4'h1, 4'h0, 4'h0, LAT);
        add(4'h5, 1'b1, 4'h5, 4'h4, 4'h0, 1);
        add(4'h5, 1'b1, 4'h5, 4'h0, 4'h0, 2);
        add(4'h1, 1'b1, 4'h5, 4'h0, 4'h0, LAT);
        add(4'h1, 1'b1, 4'h1, 4'h0, 4'h4, 1);
        add(4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 2);
        // Bits 0 and 3 move in opposite directions on the same edge.
        add(4'h8, 1'b1, 4'h1, 4'h0, 4'h0, LAT);
        add(4'h8, 1'b1, 4'h8, 4'h8, 4'h1, 1);
        add(4'h8, 1'b1, 4'h8, 4'h0, 4'h0, 2);

        foreach (vq[i]) begin
            step(vq[i].raw, vq[i].rst_n);
            check("table", vq[i].s, vq[i].r, vq[i].f);
        end

        // Bit 1 bounces with a 3-cycle half period, then settles high at cycle 40.
        for (int c = 0; c < 40 + LAT + 3; c++) begin
            logic b;
            b = (c >= 40) ? 1'b1 : (((c / 3) % 2) == 0);
            step({1'b1, 1'b0, b, 1'b0}, 1'b1);
            check("bounce", (c >= 40 + LAT) ? 4'hA : 4'h8,
                  (c == 40 + LAT) ? 4'h2 : 4'h0, 4'h0);
        end

        // Reset five cycles into a press discards progress; counting restarts after release.
        run("midrst_clr",   4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 2);
        run("midrst_idle",  4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 2);
        run("midrst_press", 4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 5);
        run("midrst_hold",  4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 2);
        run("midrst_wait",  4'h1, 1'b1, 4'h0, 4'h0, 4'h0, LAT);
        run("midrst_rise",  4'h1, 1'b1, 4'h1, 4'h1, 4'h0, 1);
        run("midrst_after", 4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 2);

        // Second press on bit 0 (toggle returns to 0 when enabled).
        run("rel_wait",  4'h0, 1'b1, 4'h1, 4'h0, 4'h0, LAT);
        run("rel_fall",  4'h0, 1'b1, 4'h0, 4'h0, 4'h1, 1);
        run("rel_after", 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 2);
        run("pr2_wait",  4'h1, 1'b1, 4'h0, 4'h0, 4'h0, LAT);
        run("pr2_rise",  4'h1, 1'b1, 4'h1, 4'h1, 4'h0, 1);
        run("pr2_after", 4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 2);

        // A dip lasting one cycle short of qualification must be rejected.
        run("glitch_lo", 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, SC - 1);
        run("glitch_hi", 4'h1, 1'b1, 4'h1, 4'h0, 4'h0, LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
